// File: rtl/priority_encoder_queue_if.sv
// Request/grant bundle for priority_encoder_queue.
// slave  : the encoder side (receives requests, presents grants).
// master : the request source / consumer side.
interface priority_encoder_queue_if #(
    parameter int N = 4
);
    // Index width is derived from N.
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         flush;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_index;
    logic [N-1:0] pending;
    logic         dup;

    modport slave (
        input  req,
        input  flush,
        input  out_ready,
        output out_valid,
        output out_index,
        output pending,
        output dup
    );

    modport master (
        output req,
        output flush,
        output out_ready,
        input  out_valid,
        input  out_index,
        input  pending,
        input  dup
    );
endinterface

// File: rtl/priority_encoder_queue.sv
// Registered priority encoder with sticky pending register and a
// valid/ready grant output. One grant per cycle while the consumer accepts.
// Optional feature macro: PRIORITY_ENCODER_QUEUE_RR_EN selects round-robin
// priority (search downward from the last granted index, with wrap);
// when undefined the highest pending index always wins.
module priority_encoder_queue #(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    priority_encoder_queue_if.slave   bus
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t       state_q;
    logic [N-1:0] pending_q;
    logic [W-1:0] index_q;
    logic         valid_q;
    logic         dup_q;

    logic [W-1:0] win_idx;
    logic         win_found;
    logic         grant;
    logic [N-1:0] grant_mask;

`ifdef PRIORITY_ENCODER_QUEUE_RR_EN
    logic [W-1:0] ptr_q;
    int unsigned  cand;
    logic [W-1:0] cand_w;

    // Round-robin winner: scan downward from ptr-1 with wrap; the loop runs
    // farthest-first so the nearest pending candidate overwrites the rest.
    always_comb begin
        win_idx = '0;
        cand    = 0;
        cand_w  = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            cand   = (32'(ptr_q) + N - k) % N;
            cand_w = W'(cand);
            if (pending_q[cand_w]) begin
                win_idx = cand_w;
            end
        end
    end
`else
    // Fixed-priority winner: highest set index of the registered pending.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                win_idx = W'(i);
            end
        end
    end
`endif

    // A grant loads when there is pending work and the output slot is free
    // (IDLE) or being freed this cycle (HOLD with out_ready).
    always_comb begin
        win_found  = |pending_q;
        grant      = win_found && ((state_q == IDLE) || bus.out_ready);
        grant_mask = grant ? (N'(1) << win_idx) : '0;
    end

    // State, pending register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            dup_q     <= 1'b0;
`ifdef PRIORITY_ENCODER_QUEUE_RR_EN
            ptr_q     <= W'(N - 1);
`endif
        end else if (bus.flush) begin
            state_q   <= IDLE;
            pending_q <= '0;
            valid_q   <= 1'b0;
            dup_q     <= 1'b0;
        end else begin
            // Grant clear happens first, then new requests set, so a req on
            // the granted bit survives as a fresh pending request.
            pending_q <= (pending_q & ~grant_mask) | bus.req;
            dup_q     <= |(bus.req & pending_q & ~grant_mask);
            if (grant) begin
                state_q <= HOLD;
                valid_q <= 1'b1;
                index_q <= win_idx;
`ifdef PRIORITY_ENCODER_QUEUE_RR_EN
                ptr_q   <= win_idx;
`endif
            end else if ((state_q == HOLD) && bus.out_ready) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_index = index_q;
    assign bus.pending   = pending_q;
    assign bus.dup       = dup_q;
endmodule
